// File: rtl/fir_job_ctrl.sv
// fir_job_ctrl: job-level sequencer for fir_datapath.
// Per job it clears the datapath, admits one h beat and len x samples,
// counts len y results, and then pulses done_o. It only gates and observes
// handshakes; stream data never passes through it.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i, len_i         job request and length (sampled in IDLE)
//   abort_i                synchronous abort (ignored in IDLE)
//   h_hs_i, x_hs_i, y_hs_i post-gating stream handshakes
//   clear_o                datapath clear
//   h_en_o, x_en_o         stream enables
//   busy_o, done_o         job in progress, one-cycle completion pulse
//   x_cnt_o, y_cnt_o       samples accepted / results observed this job
module fir_job_ctrl #(
   parameter int unsigned LEN_WIDTH    = 16,
   parameter int unsigned CLEAR_CYCLES = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [LEN_WIDTH-1:0] len_i,
   input  logic                 h_hs_i,
   input  logic                 x_hs_i,
   input  logic                 y_hs_i,
   output logic                 clear_o,
   output logic                 h_en_o,
   output logic                 x_en_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [LEN_WIDTH-1:0] x_cnt_o,
   output logic [LEN_WIDTH-1:0] y_cnt_o
);

   localparam int unsigned CLR_W = 4;
   localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLEAR_CYCLES - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CLEAR  = 3'd1;
   localparam logic [2:0] ST_LOAD_H = 3'd2;
   localparam logic [2:0] ST_STREAM = 3'd3;
   localparam logic [2:0] ST_DRAIN  = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;
   localparam logic [2:0] ST_ABORT  = 3'd6;

   logic [2:0]           state_q, state_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [LEN_WIDTH-1:0] x_cnt_q, x_cnt_d;
   logic [LEN_WIDTH-1:0] y_cnt_q, y_cnt_d;
   logic [CLR_W-1:0]     clr_q, clr_d;
   logic                 x_inc, y_inc;

   // Handshakes only count in the phases where they are legal; y never past len.
   assign x_inc = (state_q == ST_STREAM) && x_hs_i;
   assign y_inc = ((state_q == ST_STREAM) || (state_q == ST_DRAIN)) && y_hs_i
                  && (y_cnt_q < len_q);

   // Next-state and counter logic.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      x_cnt_d = x_cnt_q;
      y_cnt_d = y_cnt_q;
      clr_d   = clr_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               len_d   = len_i;
               x_cnt_d = '0;
               y_cnt_d = '0;
               clr_d   = CLR_LOAD;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (clr_q == '0) begin
               state_d = (len_q == '0) ? ST_DONE : ST_LOAD_H;
            end else begin
               clr_d = clr_q - CLR_W'(1);
            end
         end
         ST_LOAD_H: begin
            if (h_hs_i) state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (x_inc) x_cnt_d = x_cnt_q + LEN_WIDTH'(1);
            if (y_inc) y_cnt_d = y_cnt_q + LEN_WIDTH'(1);
            if (x_inc && (x_cnt_q == len_q - LEN_WIDTH'(1))) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (y_inc) y_cnt_d = y_cnt_q + LEN_WIDTH'(1);
            if (y_cnt_d == len_q) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_ABORT: begin
            if (clr_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               clr_d = clr_q - CLR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides every other transition outside IDLE.
      if (abort_i && (state_q != ST_IDLE)) begin
         state_d = ST_ABORT;
         x_cnt_d = '0;
         y_cnt_d = '0;
         clr_d   = CLR_LOAD;
      end
   end

   // State, counters and registered output decodes of the next state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         x_cnt_q <= '0;
         y_cnt_q <= '0;
         clr_q   <= '0;
         clear_o <= 1'b0;
         h_en_o  <= 1'b0;
         x_en_o  <= 1'b0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         x_cnt_q <= x_cnt_d;
         y_cnt_q <= y_cnt_d;
         clr_q   <= clr_d;
         clear_o <= (state_d == ST_CLEAR) || (state_d == ST_ABORT);
         h_en_o  <= (state_d == ST_LOAD_H);
         x_en_o  <= (state_d == ST_STREAM);
         busy_o  <= (state_d == ST_CLEAR) || (state_d == ST_LOAD_H) ||
                    (state_d == ST_STREAM) || (state_d == ST_DRAIN) ||
                    (state_d == ST_ABORT);
         done_o  <= (state_d == ST_DONE);
      end
   end

   assign x_cnt_o = x_cnt_q;
   assign y_cnt_o = y_cnt_q;

`ifndef SYNTHESIS
   // An x beat outside STREAM or a y beat beyond len means the gating upstream is broken.
   a_x_in_stream : assert property (@(posedge clk_i) disable iff (!rst_ni)
      x_hs_i |-> (state_q == ST_STREAM));
   a_y_no_overrun : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (y_hs_i && ((state_q == ST_STREAM) || (state_q == ST_DRAIN) || (state_q == ST_DONE)))
      |-> (y_cnt_q < len_q));
`endif

endmodule

// File: tb/tb_fir_job_ctrl.sv
// tb_fir_job_ctrl: directed bench for fir_job_ctrl with a job-level model
// compared against the DUT every cycle, plus literal end-of-job checks.
module tb_fir_job_ctrl;

   localparam int unsigned LW  = 16;
   localparam int unsigned CLR = 2;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [LW-1:0] len_i = '0;
   logic          h_hs_i = 1'b0;
   logic          x_hs_i = 1'b0;
   logic          y_hs_i = 1'b0;
   logic          clear_o, h_en_o, x_en_o, busy_o, done_o;
   logic [LW-1:0] x_cnt_o, y_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;
   int unsigned stall_pct = 0;

   fir_job_ctrl #(.LEN_WIDTH(LW), .CLEAR_CYCLES(CLR)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
      .len_i(len_i), .h_hs_i(h_hs_i), .x_hs_i(x_hs_i), .y_hs_i(y_hs_i),
      .clear_o(clear_o), .h_en_o(h_en_o), .x_en_o(x_en_o), .busy_o(busy_o),
      .done_o(done_o), .x_cnt_o(x_cnt_o), .y_cnt_o(y_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Job model: remaining clear cycles, whether the job is past its clear,
   // whether the h beat arrived, and sample/result tallies.
   int m_clear_left, m_x, m_y, m_len;
   bit m_active, m_h_got, m_aborting, m_done;
   bit nd, idle;

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_clear_left = 0; m_x = 0; m_y = 0; m_len = 0;
         m_active = 0; m_h_got = 0; m_aborting = 0; m_done = 0;
      end else begin
         nd   = 0;
         idle = !(m_clear_left > 0 || m_active || m_done);
         if (!idle && abort_i) begin
            m_clear_left = CLR; m_aborting = 1; m_active = 0; m_h_got = 0;
            m_x = 0; m_y = 0;
         end else if (m_clear_left > 0) begin
            m_clear_left--;
            if (m_clear_left == 0) begin
               if (m_aborting) m_aborting = 0;
               else if (m_len == 0) nd = 1;
               else m_active = 1;
            end
         end else if (m_active) begin
            if (!m_h_got) begin
               if (h_hs_i) m_h_got = 1;
            end else if (m_x < m_len) begin
               if (x_hs_i) m_x++;
               if (y_hs_i && m_y < m_len) m_y++;
            end else begin
               if (y_hs_i && m_y < m_len) m_y++;
               if (m_y == m_len) begin m_active = 0; nd = 1; end
            end
         end else if (!m_done && start_i) begin
            m_len = int'(len_i); m_x = 0; m_y = 0; m_h_got = 0; m_clear_left = CLR;
         end
         m_done = nd;
      end
   end

   // Per-cycle comparison of every output against the model.
   logic [4:0] exp_v, act_v;
   always @(negedge clk_i) begin
      exp_v = {m_clear_left > 0, m_active && !m_h_got,
               m_active && m_h_got && (m_x < m_len),
               (m_clear_left > 0) || m_active, m_done};
      act_v = {clear_o, h_en_o, x_en_o, busy_o, done_o};
      n_tests++;
      if (act_v !== exp_v || x_cnt_o !== LW'(m_x) || y_cnt_o !== LW'(m_y)) begin
         n_fail++;
         $display("FAIL cycle_model t=%0t clr/hen/xen/busy/done got %b want %b, xcnt got %0d want %0d, ycnt got %0d want %0d",
                  $time, act_v, exp_v, x_cnt_o, m_x, y_cnt_o, m_y);
      end
   end

   // Environment: handshakes only where the DUT enables them; y only for pending samples.
   always begin
      @(posedge clk_i);
      #1;
      h_hs_i = h_en_o && ($urandom_range(99) >= stall_pct);
      x_hs_i = x_en_o && ($urandom_range(99) >= stall_pct);
      y_hs_i = m_active && m_h_got && (m_x > m_y) && ($urandom_range(99) >= stall_pct);
   end

   // Event tallies used by the literal checks.
   int c_clear = 0, c_hen = 0, c_xen = 0, c_h = 0, c_x = 0, c_done = 0;
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (clear_o) c_clear++;
         if (h_en_o)  c_hen++;
         if (x_en_o)  c_xen++;
         if (h_hs_i)  c_h++;
         if (x_hs_i)  c_x++;
         if (done_o)  c_done++;
      end
   end

   int b_clear, b_hen, b_xen, b_h, b_x, b_done;

   task automatic snap();
      b_clear = c_clear; b_hen = c_hen; b_xen = c_xen;
      b_h = c_h; b_x = c_x; b_done = c_done;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_job(input int len);
      len_i   = LW'(len);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_i);
         if (done_o) begin seen = 1; break; end
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s timeout got no done_o want done_o within %0d cycles", name, budget);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      #1;
      check("reset_outputs", int'({clear_o, h_en_o, x_en_o, busy_o, done_o}), 0);
      check("reset_counts", int'(x_cnt_o) + int'(y_cnt_o), 0);
      repeat (2) @(posedge clk_i);
      #3 rst_ni = 1'b1;
      tick();

      // len = 4, no stalls.
      snap();
      start_job(4);
      wait_done("len4", 200);
      check("len4_xcnt", int'(x_cnt_o), 4);
      check("len4_ycnt", int'(y_cnt_o), 4);
      check("len4_busy_at_done", int'(busy_o), 0);
      tick();
      check("len4_clear_cycles", c_clear - b_clear, 2);
      check("len4_h_en_cycles", c_hen - b_hen, 1);
      check("len4_h_beats", c_h - b_h, 1);
      check("len4_x_beats", c_x - b_x, 4);
      check("len4_x_en_cycles", c_xen - b_xen, 4);
      check("len4_done_pulses", c_done - b_done, 1);

      // len = 0.
      snap();
      start_job(0);
      wait_done("len0", 50);
      tick();
      check("len0_clear_cycles", c_clear - b_clear, 2);
      check("len0_h_en_cycles", c_hen - b_hen, 0);
      check("len0_x_en_cycles", c_xen - b_xen, 0);
      check("len0_done_pulses", c_done - b_done, 1);

      // len = 8 with 10% stalls.
      stall_pct = 10;
      snap();
      start_job(8);
      wait_done("len8_stall", 500);
      check("len8_xcnt", int'(x_cnt_o), 8);
      check("len8_ycnt", int'(y_cnt_o), 8);
      check("len8_busy_at_done", int'(busy_o), 0);
      tick();
      check("len8_h_beats", c_h - b_h, 1);
      check("len8_x_beats", c_x - b_x, 8);
      check("len8_done_pulses", c_done - b_done, 1);
      stall_pct = 0;

      // Abort after 3 accepted samples, with a 4th beat colliding with the abort.
      start_job(8);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (x_cnt_o == LW'(3)) break;
      end
      check("abort_reached_3", int'(x_cnt_o), 3);
      snap();
      stall_pct = 100;
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      stall_pct = 0;
      repeat (4) tick();
      check("abort_xcnt", int'(x_cnt_o), 0);
      check("abort_ycnt", int'(y_cnt_o), 0);
      check("abort_busy", int'(busy_o), 0);
      check("abort_clear_cycles", c_clear - b_clear, 2);
      check("abort_no_done", c_done - b_done, 0);
      snap();
      start_job(2);
      wait_done("after_abort_len2", 100);
      check("after_abort_xcnt", int'(x_cnt_o), 2);
      tick();
      check("after_abort_done", c_done - b_done, 1);

      // start_i held high across two len = 3 jobs.
      snap();
      len_i   = LW'(3);
      start_i = 1'b1;
      wait_done("held_first", 100);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         if (busy_o) break;
      end
      start_i = 1'b0;
      wait_done("held_second", 100);
      check("held_xcnt", int'(x_cnt_o), 3);
      repeat (3) tick();
      check("held_done_pulses", c_done - b_done, 2);
      check("held_idle", int'(busy_o), 0);

      // Asynchronous reset mid-STREAM.
      start_job(8);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (x_cnt_o == LW'(2)) break;
      end
      @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      check("midreset_outputs", int'({clear_o, h_en_o, x_en_o, busy_o, done_o}), 0);
      check("midreset_counts", int'(x_cnt_o) + int'(y_cnt_o), 0);
      @(posedge clk_i);
      #3 rst_ni = 1'b1;
      snap();
      repeat (3) tick();
      check("postreset_idle", int'(busy_o), 0);
      check("postreset_no_done", c_done - b_done, 0);
      start_job(1);
      wait_done("postreset_len1", 100);
      check("postreset_xcnt", int'(x_cnt_o), 1);
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
